// File: rtl/l2_way_alloc.sv
// l2_way_alloc: per-set tree pseudo-LRU and victim selection for a 4-way L2
module l2_way_alloc #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] index,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             valid3,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             hit2,
  input  logic             hit3,
  input  logic             access,
  input  logic             fill_req,
  input  logic             fill_done,
  output logic [1:0]       victim_way,
  output logic             victim_valid,
  output logic             busy
);
  localparam int SETS = 2 ** IDX_W;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nxt;
  logic [SETS-1:0][2:0] plru, plru_nxt;
  logic [IDX_W-1:0] alloc_idx;
  logic [3:0] valid, hit;
  logic [1:0] hit_way, pick;
  // bit order is {b2, b1, b0}; touching points the tree away from way w
  function automatic logic [2:0] touch(input logic [2:0] b, input logic [1:0] w);
    return w[1] ? {~w[0], b[1], 1'b0} : {b[2], ~w[0], 1'b1};
  endfunction
  function automatic logic [1:0] walk(input logic [2:0] b);
    return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction
  assign valid = {valid3, valid2, valid1, valid0};
  assign hit = {hit3, hit2, hit1, hit0};
  assign busy = state == WAIT;
  assign victim_valid = busy;
  always_comb begin
    hit_way = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    pick = !valid[0] ? 2'd0 : !valid[1] ? 2'd1 : !valid[2] ? 2'd2 :
           !valid[3] ? 2'd3 : walk(plru[index]);
  end
  // the fill touch is applied after the hit touch so it wins on a shared set
  always_comb begin
    state_nxt = state;
    plru_nxt = plru;
    if (access && |hit) plru_nxt[index] = touch(plru_nxt[index], hit_way);
    if (state == WAIT && fill_done) begin
      plru_nxt[alloc_idx] = touch(plru_nxt[alloc_idx], victim_way);
      state_nxt = IDLE;
    end
    if (state == IDLE && fill_req) state_nxt = WAIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      plru <= '0;
      victim_way <= '0;
      alloc_idx <= '0;
    end else begin
      state <= state_nxt;
      plru <= plru_nxt;
      if (state == IDLE && fill_req) begin
        alloc_idx <= index;
        victim_way <= pick;
      end
    end
  end
endmodule

// File: tb/tb_l2_way_alloc.sv
// tb_l2_way_alloc: directed plan cases plus random traffic against a tree-PLRU reference model
module tb_l2_way_alloc;
  logic clk = 0;
  logic reset;
  logic [2:0] index;
  logic [3:0] v, h;
  logic access, fill_req, fill_done;
  logic [1:0] victim_way;
  logic victim_valid, busy;
  int checks = 0, failures = 0;
  int exp_q[$];
  bit m_b0[8], m_b1[8], m_b2[8];
  bit m_wait;
  int m_idx, m_vic;
  l2_way_alloc #(.IDX_W(3)) dut (
    .clk(clk), .reset(reset), .index(index),
    .valid0(v[0]), .valid1(v[1]), .valid2(v[2]), .valid3(v[3]),
    .hit0(h[0]), .hit1(h[1]), .hit2(h[2]), .hit3(h[3]),
    .access(access), .fill_req(fill_req), .fill_done(fill_done),
    .victim_way(victim_way), .victim_valid(victim_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic void touch_model(input int s, input int w);
    if (w < 2) begin m_b0[s] = 1; m_b1[s] = (w == 0); end
    else begin m_b0[s] = 0; m_b2[s] = (w == 2); end
  endfunction
  function automatic int victim_model(input int s, input logic [3:0] val);
    for (int w = 0; w < 4; w++) if (!val[w]) return w;
    if (m_b0[s]) return m_b2[s] ? 3 : 2;
    return m_b1[s] ? 1 : 0;
  endfunction
  // one clock edge of the reference behaviour, using the inputs held across that edge
  function automatic void model_step();
    int vic;
    bit was_wait;
    if (reset) begin
      for (int s = 0; s < 8; s++) begin m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0; end
      m_wait = 0; m_vic = 0;
      return;
    end
    was_wait = m_wait;
    vic = victim_model(index, v);
    if (access) begin
      for (int w = 0; w < 4; w++)
        if (h[w]) begin touch_model(index, w); break; end
    end
    if (was_wait && fill_done) begin touch_model(m_idx, m_vic); m_wait = 0; end
    if (!was_wait && fill_req) begin
      m_wait = 1; m_idx = index; m_vic = vic;
      exp_q.push_back(vic);
    end
  endfunction
  task automatic cyc(input bit r, input int idx, input logic [3:0] val, input logic [3:0] hv,
                     input bit a, input bit fr, input bit fd);
    reset = r; index = idx[2:0]; v = val; h = hv; access = a; fill_req = fr; fill_done = fd;
    @(posedge clk);
    model_step();
    #1;
  endtask
  logic prev_vv = 0;
  always @(negedge clk) begin
    chk("busy", busy, m_wait);
    chk("victim_valid", victim_valid, m_wait);
    if (m_wait) chk("victim_held", victim_way, m_vic);
    if (victim_valid === 1'b1 && prev_vv !== 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_victim", 1, 0);
      else chk("scoreboard_victim", victim_way, exp_q.pop_front());
    end
    prev_vv = victim_valid;
  end
  initial begin
    cyc(1, 0, 4'hf, 0, 0, 0, 0);
    cyc(1, 0, 4'hf, 0, 0, 0, 0);
    chk("reset_vv", victim_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_way", victim_way, 0);
    cyc(0, 0, 4'b0000, 0, 0, 1, 0);
    chk("set0_vv", victim_valid, 1);
    chk("set0_way", victim_way, 0);
    chk("set0_busy", busy, 1);
    cyc(0, 0, 4'hf, 0, 0, 0, 1);
    chk("set0_done_vv", victim_valid, 0);
    cyc(0, 0, 4'hf, 0, 0, 1, 0);
    chk("set0_after_fill", victim_way, 2);
    cyc(0, 0, 4'hf, 0, 0, 0, 1);
    cyc(0, 2, 4'b1011, 0, 0, 1, 0);
    chk("set2_invalid_first", victim_way, 2);
    cyc(0, 2, 4'hf, 0, 0, 0, 1);
    cyc(1, 0, 4'hf, 0, 0, 0, 0);
    cyc(0, 5, 4'hf, 4'b0001, 1, 0, 0);
    cyc(0, 5, 4'hf, 4'b0100, 1, 0, 0);
    cyc(0, 5, 4'hf, 4'b0010, 1, 0, 0);
    cyc(0, 5, 4'hf, 0, 0, 1, 0);
    chk("set5_plru", victim_way, 3);
    cyc(0, 5, 4'hf, 0, 0, 0, 1);
    cyc(0, 3, 4'b0000, 0, 0, 1, 0);
    chk("set3_first", victim_way, 0);
    cyc(0, 6, 4'b0011, 0, 0, 1, 0);
    chk("wait_ignores_req_way", victim_way, 0);
    chk("wait_ignores_req_busy", busy, 1);
    cyc(0, 6, 4'hf, 0, 0, 0, 1);
    cyc(0, 3, 4'hf, 0, 0, 1, 0);
    chk("alloc_idx_held", victim_way, 2);
    cyc(0, 3, 4'hf, 0, 0, 0, 1);
    cyc(0, 1, 4'hf, 4'b1010, 1, 0, 0);
    cyc(0, 1, 4'hf, 0, 0, 1, 0);
    chk("multi_hit_low_wins", victim_way, 2);
    cyc(0, 1, 4'hf, 0, 0, 0, 1);
    cyc(0, 7, 4'b0000, 0, 0, 1, 0);
    cyc(1, 7, 4'hf, 0, 0, 0, 0);
    chk("reset_in_wait_vv", victim_valid, 0);
    chk("reset_in_wait_busy", busy, 0);
    cyc(0, 4, 4'hf, 0, 0, 1, 0);
    chk("set4_after_reset", victim_way, 0);
    cyc(0, 4, 4'hf, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] val, hv;
      val = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom);
      hv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7), val, hv,
          $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'hf, 0, 0, 0, 1);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
